gcd_stein32: RTL and testbench

- Sequential binary-GCD (Stein) engine.
- Sits directly downstream of the trailing-zero counter `tzn32` and consumes its counts: one `tzn32` instance normalises operand A, another strips factors of two from operand B on every iteration.
- Takes two unsigned operands over a valid/ready handshake and returns their GCD over a valid/ready handshake.
- One iteration per clock; no divider and no per-bit shifting loop.

---
 rtl/gcd_pkg.sv | 25 ++
 rtl/tzn32.sv | 19 +
 rtl/gcd_stein32.sv | 114 +++++++++++
 tb/tb_gcd_stein32.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, widths and compare helpers for the binary-GCD engine
package gcd_pkg;

  localparam int GCD_WIDTH = 32;
  localparam int TZW       = $clog2(GCD_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [GCD_WIDTH-1:0] umin(input logic [GCD_WIDTH-1:0] x,
                                                input logic [GCD_WIDTH-1:0] y);
    return (x < y) ? x : y;
  endfunction

  // Larger minus smaller, so the unsigned subtract can never wrap.
  function automatic logic [GCD_WIDTH-1:0] absdiff(input logic [GCD_WIDTH-1:0] x,
                                                   input logic [GCD_WIDTH-1:0] y);
    return (x < y) ? (y - x) : (x - y);
  endfunction

endpackage

// File: rtl/tzn32.sv
// rtl/tzn32.sv - combinational trailing-zero counter; an all-zero input reports WIDTH
module tzn32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(WIDTH):0]   count_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Scan from the top so the lowest set bit is the last to write the result.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) count_o = CW'(i);
    end
  end

endmodule

// File: rtl/gcd_stein32.sv
// rtl/gcd_stein32.sv - sequential Stein GCD engine, one subtract-and-strip step per clock
module gcd_stein32
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int CNTW  = $clog2(2 * WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] gcd_o,
  output logic [CNTW-1:0]  iters_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic [WIDTH-1:0] bn, a_nx, b_nx;
  logic [TZW-1:0]   k_q, k_d, tz_a, tz_b;
  logic [CNTW-1:0]  iters_q, iters_d;

  tzn32 #(.WIDTH(WIDTH)) u_tz_a (.data_i(a_q), .count_o(tz_a));
  tzn32 #(.WIDTH(WIDTH)) u_tz_b (.data_i(b_q), .count_o(tz_b));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      gcd_q   <= gcd_d;
      iters_q <= iters_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    gcd_d   = gcd_q;
    iters_d = iters_q;
    bn      = '0;
    a_nx    = '0;
    b_nx    = '0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          iters_d = '0;
          // Zero operands bypass the loop, so tz never sees an all-zero word at a shift.
          if (a_i == '0) begin
            gcd_d   = b_i;
            state_d = DONE;
          end else if (b_i == '0) begin
            gcd_d   = a_i;
            state_d = DONE;
          end else begin
            a_d     = a_i;
            b_d     = b_i;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        k_d     = (tz_a < tz_b) ? tz_a : tz_b;
        a_d     = a_q >> tz_a;
        state_d = ITER;
      end
      ITER: begin
        bn      = b_q >> tz_b;
        a_nx    = umin(a_q, bn);
        b_nx    = absdiff(a_q, bn);
        iters_d = iters_q + CNTW'(1);
        if (b_nx == '0) begin
          gcd_d   = a_nx << k_q;
          state_d = DONE;
        end else begin
          a_d = a_nx;
          b_d = b_nx;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == NORM) || (state_q == ITER);
  assign gcd_o       = gcd_q;
  assign iters_o     = iters_q;

  // Bit-length sum shrinks every step, so the loop cannot outlast 2*WIDTH iterations.
  always_ff @(posedge clk_i) begin
    if (rst_ni && state_q == ITER) begin
      assert (iters_q < CNTW'(2 * WIDTH));
    end
  end

endmodule

// File: tb/tb_gcd_stein32.sv
// tb/tb_gcd_stein32.sv - directed and model-checked bench for the Stein GCD engine
module tb_gcd_stein32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] gcd;
  logic [6:0]  iters;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_stein32 dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .gcd_o      (gcd),
    .iters_o    (iters),
    .busy_o     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] euclid(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Handshake one operand pair, measure latency from the accept cycle, check the result.
  // With junk set, in_valid stays high carrying other operands while the engine is busy.
  task automatic run(input string tag, input logic [31:0] ra, input logic [31:0] rb,
                     input logic [31:0] eg, input int ei, input int el, input bit junk);
    int lat;
    @(negedge clk);
    check({tag, " ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    a = ra;
    b = rb;
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      a = $urandom | 32'h1;
      b = $urandom | 32'h1;
    end else begin
      in_valid = 1'b0;
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " gcd"}, gcd, eg);
    if (ei >= 0) check({tag, " iters"}, iters, 7'(ei));
    else         check({tag, " iters<=64"}, (iters <= 7'd64), 1'b1);
    if (el >= 0) check({tag, " latency"}, lat, el);
    else         check({tag, " finished"}, (lat < 200), 1'b1);
    if (out_ready) begin
      @(negedge clk);
      check({tag, " pulse"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst gcd", gcd, 32'd0);
    check("rst iters", iters, 7'd0);
    rst_n = 1'b1;

    run("48_18", 32'd48, 32'd18, 32'd6, 2, 4, 1'b0);
    run("0_0", 32'd0, 32'd0, 32'd0, 0, 1, 1'b0);
    run("0_5", 32'd0, 32'd5, 32'd5, 0, 1, 1'b0);
    run("7_0", 32'd7, 32'd0, 32'd7, 0, 1, 1'b0);
    run("pow2", 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1, 3, 1'b0);
    run("equal", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 3, 1'b0);

    // Reset two cycles after the handshake, with a nonzero previous result still held.
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'hFFFF_FFFE;
    b = 32'h0000_0003;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst busy before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst in_ready", in_ready, 1'b1);
    check("midrst gcd", gcd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst no result", seen, 0);

    // Backpressure: result and in_ready must hold while the consumer stalls.
    out_ready = 1'b0;
    run("bp", 32'd1071, 32'd462, 32'd21, 5, 7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp gcd held", gcd, 32'd21);
      check("bp in_ready low", in_ready, 1'b0);
      check("bp valid held", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release ready", in_ready, 1'b1);
    check("bp release valid", out_valid, 1'b0);

    run("busy_ignore", 32'd1071, 32'd462, 32'd21, 5, 7, 1'b1);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 4)
        1: ra = ra & 32'h0000_0FFF;
        2: begin ra = ra << (i % 17); rb = rb << (i % 13); end
        3: rb = ra * 3;
        default: ;
      endcase
      if (ra == 0) ra = 32'd12;
      if (rb == 0) rb = 32'd20;
      run("sweep", ra, rb, euclid(ra, rb), -1, -1, (i % 2) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
